// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings: transfer types, response codes, transfer qualifier.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
package ahb3lite_pkg;

  localparam int HTRANS_SIZE = 2;

  localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // True for transfer types that actually move data (NONSEQ/SEQ).
  function automatic logic htrans_is_xfer(input logic [HTRANS_SIZE-1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb3lite_decoder.sv
// AHB3-Lite address decoder, data-phase response mux and decode-error capture.
// Latency: decode and response mux are combinational; owner/error state updates on the next HCLK edge.
// Backpressure: data-phase owner holds while HREADY is low; selected slave's HREADYOUT is the bus HREADY.
module ahb3lite_decoder
  import ahb3lite_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLV_BASE = '0,
  parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLV_MASK = '0
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [HADDR_SIZE-1:0]        HADDR,
  input  logic [HTRANS_SIZE-1:0]       HTRANS,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [HDATA_SIZE-1:0]        HRDATA,
  output logic [SLAVES-1:0]            HSEL,
  input  logic [SLAVES-1:0]            HREADYOUT_S,
  input  logic [SLAVES-1:0]            HRESP_S,
  input  logic [SLAVES*HDATA_SIZE-1:0] HRDATA_S,
  output logic                         HSEL_DEF,
  input  logic                         HREADYOUT_DEF,
  input  logic                         HRESP_DEF,
  input  logic [HDATA_SIZE-1:0]        HRDATA_DEF,
  input  logic                         ERR_CLR,
  output logic                         ERR_VALID,
  output logic [HADDR_SIZE-1:0]        ERR_ADDR,
  output logic [7:0]                   ERR_CNT
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  // Who owns the current data phase.
  typedef enum logic [1:0] {
    DSEL_NONE = 2'd0,
    DSEL_SLV  = 2'd1,
    DSEL_DEF  = 2'd2
  } dsel_e;

  dsel_e                  dsel_kind;
  logic [IDX_W-1:0]       dsel_idx;

  logic [SLAVES-1:0]      hsel_dec;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;

  logic                   hready_mux;
  logic                   hresp_mux;
  logic [HDATA_SIZE-1:0]  hrdata_mux;

  logic                   err_evt;
  logic                   err_valid_q;
  logic [HADDR_SIZE-1:0]  err_addr_q;
  logic [7:0]             err_cnt_q;

  // Priority address decode: lowest-index matching region wins, so HSEL stays one-hot.
  always_comb begin
    hsel_dec = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (!hit_any && ((HADDR & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]))) begin
        hsel_dec[i] = 1'b1;
        hit_any     = 1'b1;
        hit_idx     = IDX_W'(i);
      end
    end
  end

  assign HSEL     = hsel_dec;
  assign HSEL_DEF = ~hit_any;

  // Data-phase owner advances only on completed cycles; address changes during wait states are ignored.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_kind <= DSEL_NONE;
      dsel_idx  <= '0;
    end else if (hready_mux) begin
      if (HTRANS == HTRANS_IDLE) begin
        dsel_kind <= DSEL_NONE;
        dsel_idx  <= '0;
      end else if (hit_any) begin
        dsel_kind <= DSEL_SLV;
        dsel_idx  <= hit_idx;
      end else begin
        dsel_kind <= DSEL_DEF;
        dsel_idx  <= '0;
      end
    end
  end

  // Route the owning slave's response back; no owner means an always-ready OKAY with zero data.
  always_comb begin
    hready_mux = 1'b1;
    hresp_mux  = HRESP_OKAY;
    hrdata_mux = '0;
    case (dsel_kind)
      DSEL_SLV: begin
        for (int i = 0; i < SLAVES; i++) begin
          if (dsel_idx == IDX_W'(i)) begin
            hready_mux = HREADYOUT_S[i];
            hresp_mux  = HRESP_S[i];
            hrdata_mux = HRDATA_S[i*HDATA_SIZE +: HDATA_SIZE];
          end
        end
      end
      DSEL_DEF: begin
        hready_mux = HREADYOUT_DEF;
        hresp_mux  = HRESP_DEF;
        hrdata_mux = HRDATA_DEF;
      end
      default: ;
    endcase
  end

  assign HREADY = hready_mux;
  assign HRESP  = hresp_mux;
  assign HRDATA = hrdata_mux;

  // A decode error is a real transfer accepted into an unmapped region.
  assign err_evt = hready_mux && htrans_is_xfer(HTRANS) && ~hit_any;

  // Error status: first address is sticky until cleared; a coincident error beats the clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else if (err_evt) begin
      if (!err_valid_q || ERR_CLR) begin
        err_addr_q <= HADDR;
      end
      err_valid_q <= 1'b1;
      if (ERR_CLR) begin
        err_cnt_q <= 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end else if (ERR_CLR) begin
      err_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end
  end

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;
  assign ERR_CNT   = err_cnt_q;

endmodule
